// File: rtl/cpu_oci_trace_capture.sv
// ============================================================================
// cpu_oci_trace_capture
// ----------------------------------------------------------------------------
// Debug trace capture for the CPU OCI.
//
// Trace words are packed into frames of PACK slots. Each frame is queued in a
// DEPTH-frame show-ahead FIFO and handed out over a valid/ready port. When the
// test ends, the partial frame is flushed and the FIFO is drained.
// test_has_ended rises once both steps are complete.
//
// Optional feature (compile-time macro):
//   TRACE_OVERFLOW_CNT_EN - adds a 16-bit saturating count of dropped frames
//                           on port overflow_count.
//
// Ports:
//   clk             in   1                 system clock, rising edge
//   reset_n         in   1                 asynchronous active-low reset
//   trace_valid     in   1                 trace word present this cycle
//   trace_data      in   DATA_W            trace word
//   test_ending     in   1                 level; requests flush and drain
//   frame_valid     out  1                 frame_data/frame_count are valid
//   frame_ready     in   1                 consumer accepts the frame
//   frame_data      out  DATA_W*PACK       slot 0 in the LSBs; unused slots 0
//   frame_count     out  $clog2(PACK+1)    number of valid slots (1..PACK)
//   fifo_level      out  $clog2(DEPTH+1)   frames stored, incl. the one shown
//   overflow        out  1                 sticky; set when a frame is dropped
//   test_has_ended  out  1                 flush and drain complete
//   overflow_count  out  16                dropped frames, saturating
//                                          (TRACE_OVERFLOW_CNT_EN only)
// ============================================================================
module cpu_oci_trace_capture #(
    parameter int DATA_W = 30,
    parameter int PACK   = 4,
    parameter int DEPTH  = 8
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         trace_valid,
    input  logic [DATA_W-1:0]            trace_data,
    input  logic                         test_ending,
    output logic                         frame_valid,
    input  logic                         frame_ready,
    output logic [DATA_W*PACK-1:0]       frame_data,
    output logic [$clog2(PACK+1)-1:0]    frame_count,
    output logic [$clog2(DEPTH+1)-1:0]   fifo_level,
    output logic                         overflow,
    output logic                         test_has_ended
`ifdef TRACE_OVERFLOW_CNT_EN
    ,
    output logic [15:0]                  overflow_count
`endif
);

    localparam int CW = $clog2(PACK + 1);
    localparam int LW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = $clog2(PACK);
    localparam int FW = DATA_W * PACK;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        FLUSH = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t          state;
    state_t          state_next;

    logic [FW-1:0]   pack_buf;
    logic [FW-1:0]   pack_buf_next;
    logic [PW-1:0]   pack_cnt;
    logic [PW-1:0]   pack_cnt_next;

    logic            push;
    logic [FW-1:0]   push_data;
    logic [CW-1:0]   push_cnt;

    logic [FW-1:0]   mem_data [DEPTH];
    logic [CW-1:0]   mem_cnt  [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [LW-1:0]   level;

    logic            fifo_full;
    logic            pop;
    logic            push_accept;
    logic            push_drop;

    // ------------------------------------------------------------------------
    // Control state register and the pack buffer. The buffer is cleared every
    // time a frame leaves it, whether the FIFO takes the frame or drops it.
    // This keeps the unused slots of any later partial frame at zero.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= RUN;
            pack_buf <= '0;
            pack_cnt <= '0;
        end else begin
            state    <= state_next;
            pack_buf <= pack_buf_next;
            pack_cnt <= pack_cnt_next;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state, capture and push generation.
    // In RUN, a word that fills the last slot is pushed in the same cycle as
    // it is written. This means a test_ending that arrives with the final word
    // leaves nothing for FLUSH to do.
    // ------------------------------------------------------------------------
    always_comb begin
        state_next    = state;
        pack_buf_next = pack_buf;
        pack_cnt_next = pack_cnt;
        push          = 1'b0;
        push_data     = '0;
        push_cnt      = '0;

        case (state)
            RUN: begin
                if (trace_valid) begin
                    pack_buf_next[int'(pack_cnt)*DATA_W +: DATA_W] = trace_data;
                    if (pack_cnt == PW'(PACK - 1)) begin
                        push          = 1'b1;
                        push_data     = pack_buf_next;
                        push_cnt      = CW'(PACK);
                        pack_buf_next = '0;
                        pack_cnt_next = '0;
                    end else begin
                        pack_cnt_next = pack_cnt + 1'b1;
                    end
                end
                if (test_ending) begin
                    state_next = FLUSH;
                end
            end
            FLUSH: begin
                if (pack_cnt != '0) begin
                    push      = 1'b1;
                    push_data = pack_buf;
                    push_cnt  = CW'(pack_cnt);
                end
                pack_buf_next = '0;
                pack_cnt_next = '0;
                state_next    = DRAIN;
            end
            DRAIN: begin
                if (level == '0) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = DONE;
            end
            default: begin
                state_next = RUN;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // FIFO handshake. A push into a full FIFO succeeds only when the head is
    // leaving in the same cycle. Otherwise the frame is lost.
    // ------------------------------------------------------------------------
    always_comb begin
        fifo_full   = (level == LW'(DEPTH));
        pop         = frame_valid & frame_ready;
        push_accept = push & (~fifo_full | pop);
        push_drop   = push & fifo_full & ~pop;
    end

    // ------------------------------------------------------------------------
    // Frame storage. This is plain memory with no reset. The output gating
    // below hides stale contents whenever the FIFO is empty.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (push_accept) begin
            mem_data[wr_ptr] <= push_data;
            mem_cnt[wr_ptr]  <= push_cnt;
        end
    end

    // ------------------------------------------------------------------------
    // Pointers and occupancy. DEPTH is a power of two, so the pointers wrap
    // naturally. When the FIFO is full, a simultaneous push and pop write the
    // slot that is being read out. That is safe because the head has already
    // been consumed in that cycle.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_accept) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_accept, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Drop reporting. The flag is sticky. The optional counter saturates.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overflow <= 1'b0;
        end else if (push_drop) begin
            overflow <= 1'b1;
        end
    end

`ifdef TRACE_OVERFLOW_CNT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overflow_count <= '0;
        end else if (push_drop && (overflow_count != 16'hFFFF)) begin
            overflow_count <= overflow_count + 16'd1;
        end
    end
`endif

    // ------------------------------------------------------------------------
    // Completion flag. It is registered from the next state, so it is high
    // exactly while the FSM sits in DONE.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            test_has_ended <= 1'b0;
        end else begin
            test_has_ended <= (state_next == DONE);
        end
    end

    // ------------------------------------------------------------------------
    // Show-ahead output. The head entry is presented directly. Data and count
    // are forced to zero while the FIFO is empty.
    // ------------------------------------------------------------------------
    always_comb begin
        frame_valid = (level != '0);
        fifo_level  = level;
        frame_data  = frame_valid ? mem_data[rd_ptr] : '0;
        frame_count = frame_valid ? mem_cnt[rd_ptr]  : '0;
    end

endmodule

// File: tb/tb_cpu_oci_trace_capture.sv
// ============================================================================
// tb_cpu_oci_trace_capture
// ----------------------------------------------------------------------------
// Scoreboard bench for cpu_oci_trace_capture.
//
// The stimulus driver runs a behavioural model built from word lists and a
// frame queue. It pushes every frame it expects to see into exp_q. A separate
// monitor pops exp_q on each output handshake and compares the frames.
// Compile with TRACE_OVERFLOW_CNT_EN defined to also check overflow_count.
// ============================================================================
module tb_cpu_oci_trace_capture;

    localparam int DATA_W = 30;
    localparam int PACK   = 4;
    localparam int DEPTH  = 8;
    localparam int FW     = DATA_W * PACK;

    localparam int P_RUN   = 0;
    localparam int P_FLUSH = 1;
    localparam int P_DRAIN = 2;
    localparam int P_DONE  = 3;

    typedef struct {
        logic [FW-1:0] data;
        int            cnt;
    } frame_t;

    logic                         clk;
    logic                         reset_n;
    logic                         trace_valid;
    logic [DATA_W-1:0]            trace_data;
    logic                         test_ending;
    logic                         frame_valid;
    logic                         frame_ready;
    logic [FW-1:0]                frame_data;
    logic [$clog2(PACK+1)-1:0]    frame_count;
    logic [$clog2(DEPTH+1)-1:0]   fifo_level;
    logic                         overflow;
    logic                         test_has_ended;
`ifdef TRACE_OVERFLOW_CNT_EN
    logic [15:0]                  overflow_count;
`endif

    int              n_pass  = 0;
    int              n_total = 0;

    frame_t          exp_q[$];
    logic [DATA_W-1:0] cur[$];
    int              m_level;
    int              m_phase;
    bit              m_ovf;
    int              m_ocnt;

    cpu_oci_trace_capture #(
        .DATA_W (DATA_W),
        .PACK   (PACK),
        .DEPTH  (DEPTH)
    ) dut (
`ifdef TRACE_OVERFLOW_CNT_EN
        .overflow_count (overflow_count),
`endif
        .clk            (clk),
        .reset_n        (reset_n),
        .trace_valid    (trace_valid),
        .trace_data     (trace_data),
        .test_ending    (test_ending),
        .frame_valid    (frame_valid),
        .frame_ready    (frame_ready),
        .frame_data     (frame_data),
        .frame_count    (frame_count),
        .fifo_level     (fifo_level),
        .overflow       (overflow),
        .test_has_ended (test_has_ended)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic frame_t make_frame();
        frame_t f;
        f.data = '0;
        foreach (cur[i]) f.data[i*DATA_W +: DATA_W] = cur[i];
        f.cnt = cur.size();
        return f;
    endfunction

    // Monitor: every handshake consumes the oldest expected frame.
    always @(negedge clk) begin
        if (reset_n && frame_valid && frame_ready) begin
            if (exp_q.size() == 0) begin
                n_total++;
                $display("[TB] FAIL unexpected_frame actual=%0h required=none", frame_data);
            end else begin
                frame_t e;
                e = exp_q.pop_front();
                check("frame_data",  128'(frame_data),  128'(e.data));
                check("frame_count", 128'(frame_count), 128'(e.cnt));
            end
        end
    end

    task automatic check_output();
        check("fifo_level",     128'(fifo_level),     128'(m_level));
        check("overflow",       128'(overflow),       128'(m_ovf));
        check("test_has_ended", 128'(test_has_ended), 128'(m_phase == P_DONE));
`ifdef TRACE_OVERFLOW_CNT_EN
        check("overflow_count", 128'(overflow_count), 128'(m_ocnt));
`endif
    endtask

    // One clock cycle: check the visible state, drive the inputs, then
    // advance the model by the same cycle.
    task automatic apply_stimulus(input logic tv, input logic [DATA_W-1:0] td,
                                  input logic te, input logic rdy);
        bit     pop;
        bit     push;
        frame_t f;
        check_output();
        trace_valid = tv;
        trace_data  = td;
        test_ending = te;
        frame_ready = rdy;
        pop  = (m_level > 0) && rdy;
        push = 1'b0;
        f.data = '0;
        f.cnt  = 0;
        case (m_phase)
            P_RUN: begin
                if (tv) begin
                    cur.push_back(td);
                    if (cur.size() == PACK) begin
                        f = make_frame();
                        push = 1'b1;
                        cur.delete();
                    end
                end
                if (te) m_phase = P_FLUSH;
            end
            P_FLUSH: begin
                if (cur.size() > 0) begin
                    f = make_frame();
                    push = 1'b1;
                end
                cur.delete();
                m_phase = P_DRAIN;
            end
            P_DRAIN: begin
                if (m_level == 0) m_phase = P_DONE;
            end
            default: ;
        endcase
        if (push) begin
            if (m_level < DEPTH || pop) begin
                exp_q.push_back(f);
                m_level++;
            end else begin
                m_ovf = 1'b1;
                if (m_ocnt != 16'hFFFF) m_ocnt++;
            end
        end
        if (pop) m_level--;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) apply_stimulus(1'b0, '0, 1'b0, rdy);
    endtask

    task automatic do_reset();
        reset_n     = 1'b0;
        trace_valid = 1'b0;
        trace_data  = '0;
        test_ending = 1'b0;
        frame_ready = 1'b0;
        #1;
        check("rst_frame_valid",    128'(frame_valid),    128'(0));
        check("rst_frame_data",     128'(frame_data),     128'(0));
        check("rst_frame_count",    128'(frame_count),    128'(0));
        check("rst_fifo_level",     128'(fifo_level),     128'(0));
        check("rst_overflow",       128'(overflow),       128'(0));
        check("rst_test_has_ended", 128'(test_has_ended), 128'(0));
`ifdef TRACE_OVERFLOW_CNT_EN
        check("rst_overflow_count", 128'(overflow_count), 128'(0));
`endif
        exp_q.delete();
        cur.delete();
        m_level = 0;
        m_phase = P_RUN;
        m_ovf   = 1'b0;
        m_ocnt  = 0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n = 1'b0;
        #2;
        do_reset();

        // Four words packed into one full frame.
        for (int i = 1; i <= 4; i++) apply_stimulus(1'b1, DATA_W'(i), 1'b0, 1'b1);
        idle(3, 1'b1);
        check("queue_empty_1", 128'(exp_q.size()), 128'(0));

        // Partial frame flushed at test end, then DONE holds.
        do_reset();
        apply_stimulus(1'b1, DATA_W'('hA), 1'b0, 1'b1);
        apply_stimulus(1'b1, DATA_W'('hB), 1'b0, 1'b1);
        apply_stimulus(1'b0, '0, 1'b1, 1'b1);
        idle(6, 1'b1);
        apply_stimulus(1'b1, DATA_W'('h5), 1'b1, 1'b1);
        idle(2, 1'b1);

        // Overfill with ready low, push and pop while full, then drain.
        do_reset();
        for (int i = 0; i < (DEPTH + 1) * PACK; i++)
            apply_stimulus(1'b1, DATA_W'($urandom), 1'b0, 1'b0);
        idle(2, 1'b0);
        for (int i = 0; i < PACK - 1; i++)
            apply_stimulus(1'b1, DATA_W'($urandom), 1'b0, 1'b0);
        apply_stimulus(1'b1, DATA_W'($urandom), 1'b0, 1'b1);
        idle(2, 1'b0);
        idle(DEPTH + 2, 1'b1);
        check("queue_empty_3", 128'(exp_q.size()), 128'(0));

        // test_ending arrives together with the frame-completing word.
        do_reset();
        for (int i = 1; i <= 3; i++) apply_stimulus(1'b1, DATA_W'(i), 1'b0, 1'b0);
        apply_stimulus(1'b1, DATA_W'(4), 1'b1, 1'b0);
        idle(3, 1'b0);
        idle(5, 1'b1);

        // Reset in the middle of a drain with three frames stored.
        do_reset();
        for (int i = 0; i < 3 * PACK; i++)
            apply_stimulus(1'b1, DATA_W'($urandom), 1'b0, 1'b0);
        apply_stimulus(1'b0, '0, 1'b1, 1'b0);
        idle(3, 1'b0);
        do_reset();
        for (int i = 0; i < PACK + 2; i++)
            apply_stimulus(1'b1, DATA_W'($urandom), 1'b0, 1'b1);
        idle(3, 1'b1);

        // Randomized rounds with occasional back-pressure and overflow.
        for (int r = 0; r < 4; r++) begin
            do_reset();
            for (int i = 0; i < 150; i++)
                apply_stimulus($urandom_range(0, 99) < 60, DATA_W'($urandom),
                               i == 120, $urandom_range(0, 99) < 30);
            idle(DEPTH + 6, 1'b1);
            check("rand_queue_empty", 128'(exp_q.size()), 128'(0));
        end

        check_output();
        $display("[TB] %0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
